pmp_scan: RTL and testbench
===========================

# pmp_scan

Sequential, parametrised PMP region checker for the MMU. It accepts one physical-address request at a time and scans `PMP_ENTRIES` PMP entries, `LANES` entries per cycle, in priority order. It reports the lowest-indexed matching entry, its permissions, and whether the access is only partially covered by that entry. It sits between the LSU/IFU translation path and the fault logic, and serves implementations with large PMP counts, where a single-cycle flat decode misses timing.

## Interface
- `PA_BITS`, 56, physical address width.
- `PMP_ENTRIES`, 16, number of PMP entries; must be a multiple of `LANES`.
- `LANES`, 4, entries evaluated per scan cycle; power of two.
- `clk` input 1: clock.
- `reset` input 1: synchronous, active-high reset.
- `ReqValid` input 1: request present.
- `ReqReady` output 1: block can accept a request.
- `PhysicalAddress` input PA_BITS: access address; naturally aligned to its size.
- `Size` input 2: log2 of the access size in bytes (0..3).
- `PMPCfg` input PMP_ENTRIES×8: per-entry cfg bytes. Bits: [7] L, [4:3] A, [2] X, [1] W, [0] R.
- `PMPAdr` input PMP_ENTRIES×(PA_BITS-2): pmpaddr registers.
- `Flush` input 1: PMP CSR write or sfence; aborts the current scan.
- `RespValid` output 1: result valid.
- `RespReady` input 1: consumer accepts the result.
- `Match` output 1: some entry matched.
- `MatchIdx` output $clog2(PMP_ENTRIES): index of the matching entry.
- `Partial` output 1: the matching entry covers only part of the access bytes.
- `L`, `X`, `W`, `R` outputs 1 each: cfg bits of the matching entry; all 0 when `Match`=0.

## Operation
- **States:** IDLE, SCAN, DONE. `ReqReady` = (state==IDLE).
- **IDLE:** on `ReqValid`, latch `PhysicalAddress` and `Size`, set scan base Base=0, and go to SCAN.
- **SCAN:** each cycle, evaluate entries Base..Base+LANES-1.
  - If any entry in the group matches, the lowest index in the group wins. Register the result and go to DONE.
  - Otherwise Base += LANES. If Base reaches PMP_ENTRIES, register Match=0 with all other result fields 0 and go to DONE.
- **DONE:** hold `RespValid`=1 with stable outputs until `RespReady`=1, then go to IDLE.
- **Flush:** in any state, go to IDLE and drop `RespValid`. No response is produced for the aborted request. Flush takes priority over acceptance in the same cycle.
- `PMPCfg` and `PMPAdr` must be stable between acceptance and response; CSR writers assert `Flush`.
- **Per-entry match:** compute Last = PA | ((1<<Size)-1). StartIn and LastIn are computed by the same rule.
  - **OFF (A=00):** never matches.
  - **TOR (A=01):** Lo = {PMPAdr[i-1],2'b00}, with Lo=0 for entry 0; Hi = {PMPAdr[i],2'b00}. In-range means Lo ≤ addr < Hi, compared unsigned at PA_BITS+1 bits. If Lo ≥ Hi, the entry never matches.
  - **NA4/NAPOT (A=1x):** the mask is formed from the trailing ones of PMPAdr, plus 1 for NAPOT, with the bottom 2 bits always masked. In-range means the addr bits outside the mask equal the base.
  - Match = StartIn | LastIn; Partial = Match & ~(StartIn & LastIn).
  - Accesses are aligned and regions are at least 4 B, so these two probes are exact.

## Timing
- **Reset:** state IDLE, `ReqReady`=1, and `RespValid`, `Match`, `MatchIdx`, `Partial`, L/X/W/R all 0.
- Acceptance happens in cycle k, when `ReqValid`&`ReqReady`.
- The hit group is g = MatchIdx/LANES. `RespValid` rises in cycle k+g+2.
- A no-match result has `RespValid` in cycle k+PMP_ENTRIES/LANES+1.
- `RespValid` and the outputs change only on entry to DONE or on leaving it.
- A new request can be accepted the cycle after the `RespValid`&`RespReady` handshake; there is no back-to-back overlap.
- Reset mid-scan: the block returns to IDLE and no response is produced.

## Configuration
- `PMP_SCAN_HITCACHE_EN`:
  - **Defined:** a one-entry cache holds {PA[PA_BITS-1:2], Size, result} of the last completed scan. A request whose granule and Size both equal the cached values goes IDLE→DONE directly, giving `RespValid` in cycle k+1. The cache is invalidated on `Flush` and `reset`.
  - **Undefined:** there is no cache, and every request scans.

## Structure
- **Shared package `pmp_pkg`:**
  - A-field encodings OFF/TOR/NA4/NAPOT.
  - The `pmpscan_state_t` enum.
  - A result struct holding Match, Idx, Partial, L, X, W, R.
- **Sub-module `pmp_entry_match`:** combinational matcher, with inputs PA, Last, Lo, PMPAdr, and cfg, and outputs Match and Partial. It is instantiated LANES times, on mux-selected entries.

## Test plan
Configuration for all scenarios: PA_BITS=34, PMP_ENTRIES=16, LANES=4.
- **NAPOT hit:** entry 5 NAPOT, PMPAdr=0x41FF (4 KB at 0x10000), cfg R/W. Request PA=0x10010, Size=2 -> Match=1, MatchIdx=5, Partial=0, R=W=1, X=0, with `RespValid` 3 cycles after acceptance.
- **TOR partial:** entry 0 OFF with PMPAdr=0x1000; entry 1 TOR with PMPAdr=0x1001, range [0x4000,0x4004). Request PA=0x4000, Size=3 -> Match=1, MatchIdx=1, Partial=1.
- **Priority:** entries 2 and 3 are both NAPOT covering 0x8000. Request PA=0x8000 -> MatchIdx=2, with `RespValid` 2 cycles after acceptance.
- **No match:** all entries OFF. Any request -> Match=0 and L/X/W/R=0, with `RespValid` 5 cycles after acceptance.
- **Backpressure and flush:**
  - `RespReady` held low for 3 cycles -> outputs are held stable.
  - `Flush` in the second scan cycle -> IDLE next cycle, no `RespValid`, `ReqReady`=1.
- **Hit cache (`PMP_SCAN_HITCACHE_EN`):**
  - Repeating the first scenario's request -> `RespValid` 1 cycle after acceptance with identical outputs.
  - After `Flush`, the same request -> 3-cycle latency.

Source files
------------

// File: rtl/pmp_pkg.sv
// Shared types for the sequential PMP scanner: A-field encodings, FSM states, result record.
package pmp_pkg;

   typedef enum logic [1:0] {
      A_OFF   = 2'b00,
      A_TOR   = 2'b01,
      A_NA4   = 2'b10,
      A_NAPOT = 2'b11
   } pmp_a_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      SCAN = 2'b01,
      DONE = 2'b10
   } pmpscan_state_t;

   // Wide enough for any practical entry count; the top truncates to its own index width.
   localparam int IDX_W = 8;

   typedef struct packed {
      logic             match;
      logic [IDX_W-1:0] idx;
      logic             partial;
      logic             l;
      logic             x;
      logic             w;
      logic             r;
   } pmp_res_t;

endpackage

// File: rtl/pmp_entry_match.sv
// Combinational single-entry PMP matcher: probes the first and last byte of an aligned access.
module pmp_entry_match
   import pmp_pkg::*;
#(
   parameter int PA_BITS = 56
) (
   input  logic [PA_BITS-1:0] pa_i,
   input  logic [PA_BITS-1:0] last_i,
   input  logic [PA_BITS-1:0] lo_i,
   input  logic [PA_BITS-3:0] adr_i,
   input  logic [7:0]         cfg_i,
   output logic               match_o,
   output logic               partial_o
);
   localparam int AW = PA_BITS - 2;

   pmp_a_t             a;
   logic [PA_BITS-1:0] hi;
   logic [PA_BITS-1:0] mask;
   logic [AW-1:0]      napot_bits;
   logic               start_in;
   logic               last_in;
   logic               unused_cfg;

   assign a          = pmp_a_t'(cfg_i[4:3]);
   assign hi         = {adr_i, 2'b00};
   // Trailing ones plus the next bit: exactly the NAPOT size field.
   assign napot_bits = adr_i ^ (adr_i + AW'(1));
   assign unused_cfg = ^{cfg_i[7:5], cfg_i[2:0]};

   always_comb begin
      start_in = 1'b0;
      last_in  = 1'b0;
      mask     = {{AW{1'b0}}, 2'b11};
      case (a)
         A_TOR: begin
            start_in = ({1'b0, lo_i} <= {1'b0, pa_i})   && ({1'b0, pa_i}   < {1'b0, hi}) && (lo_i < hi);
            last_in  = ({1'b0, lo_i} <= {1'b0, last_i}) && ({1'b0, last_i} < {1'b0, hi}) && (lo_i < hi);
         end
         A_NA4, A_NAPOT: begin
            if (a == A_NAPOT) mask = {napot_bits, 2'b11};
            start_in = ((pa_i   ^ hi) & ~mask) == '0;
            last_in  = ((last_i ^ hi) & ~mask) == '0;
         end
         default: ;
      endcase
   end

   assign match_o   = start_in | last_in;
   assign partial_o = match_o & ~(start_in & last_in);

endmodule

// File: rtl/pmp_scan.sv
// Sequential PMP checker scanning LANES entries per cycle in priority order.
// Optional one-entry result cache enabled by defining PMP_SCAN_HITCACHE_EN.
module pmp_scan
   import pmp_pkg::*;
#(
   parameter int PA_BITS     = 56,
   parameter int PMP_ENTRIES = 16,
   parameter int LANES       = 4
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              ReqValid,
   output logic                              ReqReady,
   input  logic [PA_BITS-1:0]                PhysicalAddress,
   input  logic [1:0]                        Size,
   input  logic [PMP_ENTRIES*8-1:0]          PMPCfg,
   input  logic [PMP_ENTRIES*(PA_BITS-2)-1:0] PMPAdr,
   input  logic                              Flush,
   output logic                              RespValid,
   input  logic                              RespReady,
   output logic                              Match,
   output logic [$clog2(PMP_ENTRIES)-1:0]    MatchIdx,
   output logic                              Partial,
   output logic                              L,
   output logic                              X,
   output logic                              W,
   output logic                              R
);
   localparam int AW   = PA_BITS - 2;
   localparam int IW   = $clog2(PMP_ENTRIES);
   localparam int NGRP = PMP_ENTRIES / LANES;
   localparam int GW   = (NGRP > 1) ? $clog2(NGRP) : 1;

   pmpscan_state_t     state_q;
   logic [GW-1:0]      grp_q;
   logic [PA_BITS-1:0] pa_q;
   logic [1:0]         sz_q;
   pmp_res_t           res_q;

   logic [PA_BITS-1:0]                  last;
   logic [2:0]                          szm;
   logic [LANES-1:0][AW-1:0]            adr_l;
   logic [LANES-1:0][7:0]               cfg_l;
   logic [LANES-1:0][PA_BITS-1:0]       lo_l;
   logic [LANES-1:0][IW-1:0]            idx_l;
   logic [LANES-1:0]                    m_l;
   logic [LANES-1:0]                    p_l;
   logic                                hit;
   logic                                last_grp;
   pmp_res_t                            hres;
   logic [IDX_W-1:0]                    unused_idx;

   assign szm      = 3'((4'd1 << sz_q) - 4'd1);
   assign last     = pa_q | {{(PA_BITS-3){1'b0}}, szm};
   assign last_grp = (grp_q == GW'(NGRP-1));

   // Route the current group's entries (and each one's TOR lower bound) to the lanes.
   always_comb begin
      for (int j = 0; j < LANES; j++) begin
         idx_l[j] = IW'(int'(grp_q) * LANES + j);
         adr_l[j] = PMPAdr[int'(idx_l[j])*AW +: AW];
         cfg_l[j] = PMPCfg[int'(idx_l[j])*8 +: 8];
         lo_l[j]  = (idx_l[j] == '0) ? '0 :
                    {PMPAdr[((idx_l[j] == '0) ? 0 : int'(idx_l[j]) - 1)*AW +: AW], 2'b00};
      end
   end

   for (genvar j = 0; j < LANES; j++) begin : g_lane
      pmp_entry_match #(.PA_BITS(PA_BITS)) u_match (
         .pa_i      (pa_q),
         .last_i    (last),
         .lo_i      (lo_l[j]),
         .adr_i     (adr_l[j]),
         .cfg_i     (cfg_l[j]),
         .match_o   (m_l[j]),
         .partial_o (p_l[j])
      );
   end

   // Walk downward so the lowest-indexed matching lane is the final writer.
   always_comb begin
      hit  = 1'b0;
      hres = '0;
      for (int j = LANES-1; j >= 0; j--) begin
         if (m_l[j]) begin
            hit          = 1'b1;
            hres.match   = 1'b1;
            hres.idx     = IDX_W'(idx_l[j]);
            hres.partial = p_l[j];
            hres.l       = cfg_l[j][7];
            hres.x       = cfg_l[j][2];
            hres.w       = cfg_l[j][1];
            hres.r       = cfg_l[j][0];
         end
      end
   end

`ifdef PMP_SCAN_HITCACHE_EN
   logic           cv_q;
   logic [AW-1:0]  cpa_q;
   logic [1:0]     csz_q;
   pmp_res_t       cres_q;
   logic           chit;

   assign chit = cv_q && (PhysicalAddress[PA_BITS-1:2] == cpa_q) && (Size == csz_q);

   always_ff @(posedge clk) begin
      if (reset || Flush) begin
         cv_q   <= 1'b0;
         cpa_q  <= '0;
         csz_q  <= '0;
         cres_q <= '0;
      end else if (state_q == SCAN && (hit || last_grp)) begin
         cv_q   <= 1'b1;
         cpa_q  <= pa_q[PA_BITS-1:2];
         csz_q  <= sz_q;
         cres_q <= hit ? hres : '0;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         grp_q   <= '0;
         pa_q    <= '0;
         sz_q    <= '0;
         res_q   <= '0;
      end else if (Flush) begin
         state_q <= IDLE;
      end else begin
         case (state_q)
            IDLE: if (ReqValid) begin
               pa_q  <= PhysicalAddress;
               sz_q  <= Size;
               grp_q <= '0;
`ifdef PMP_SCAN_HITCACHE_EN
               if (chit) begin
                  res_q   <= cres_q;
                  state_q <= DONE;
               end else begin
                  state_q <= SCAN;
               end
`else
               state_q <= SCAN;
`endif
            end
            SCAN: begin
               if (hit) begin
                  res_q   <= hres;
                  state_q <= DONE;
               end else if (last_grp) begin
                  res_q   <= '0;
                  state_q <= DONE;
               end else begin
                  grp_q <= grp_q + GW'(1);
               end
            end
            DONE: if (RespReady) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign ReqReady   = (state_q == IDLE);
   assign RespValid  = (state_q == DONE);
   assign Match      = res_q.match;
   assign MatchIdx   = res_q.idx[IW-1:0];
   assign Partial    = res_q.partial;
   assign L          = res_q.l;
   assign X          = res_q.x;
   assign W          = res_q.w;
   assign R          = res_q.r;
   assign unused_idx = res_q.idx;

endmodule

// File: tb/tb_pmp_scan.sv
// Directed + randomized scoreboard bench for pmp_scan (PA_BITS=34, 16 entries, 4 lanes).
module tb_pmp_scan;
   localparam int PA = 34;
   localparam int NE = 16;
   localparam int LN = 4;
   localparam int AW = PA - 2;
`ifdef PMP_SCAN_HITCACHE_EN
   localparam bit CACHE = 1'b1;
`else
   localparam bit CACHE = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              ReqValid = 1'b0;
   logic              ReqReady;
   logic [PA-1:0]     PhysicalAddress = '0;
   logic [1:0]        Size = '0;
   logic [NE*8-1:0]   PMPCfg = '0;
   logic [NE*AW-1:0]  PMPAdr = '0;
   logic              Flush = 1'b0;
   logic              RespValid;
   logic              RespReady = 1'b0;
   logic              Match;
   logic [3:0]        MatchIdx;
   logic              Partial, L, X, W, R;

   always #5 clk = ~clk;

   pmp_scan #(.PA_BITS(PA), .PMP_ENTRIES(NE), .LANES(LN)) dut (
      .clk(clk), .reset(reset), .ReqValid(ReqValid), .ReqReady(ReqReady),
      .PhysicalAddress(PhysicalAddress), .Size(Size), .PMPCfg(PMPCfg), .PMPAdr(PMPAdr),
      .Flush(Flush), .RespValid(RespValid), .RespReady(RespReady), .Match(Match),
      .MatchIdx(MatchIdx), .Partial(Partial), .L(L), .X(X), .W(W), .R(R)
   );

   typedef struct {
      bit m; int idx; bit p; bit l; bit x; bit w; bit r; int lat;
   } exp_t;

   exp_t          sbq[$];
   int            ncmp = 0;
   int            nfail = 0;
   bit            cv = 1'b0;
   logic [AW-1:0] cpa = '0;
   logic [1:0]    csz = '0;

   task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
      ncmp++;
      assert (got === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_ent(int i, logic [7:0] c, logic [AW-1:0] a);
      PMPCfg[i*8 +: 8] = c;
      PMPAdr[i*AW +: AW] = a;
   endtask

   // Reference: byte-range model of each region, probing first and last byte.
   function automatic exp_t model(logic [PA-1:0] pa, logic [1:0] sz);
      exp_t e;
      longint a0, a1, lo, hi, rs, ad;
      int t;
      logic [7:0] c;
      bit sin, lin;
      e = '{default: 0};
      a0 = longint'(pa);
      a1 = a0 + (longint'(1) << sz) - 1;
      for (int i = 0; i < NE; i++) begin
         c  = PMPCfg[i*8 +: 8];
         ad = longint'(PMPAdr[i*AW +: AW]);
         lo = 0; hi = 0;
         case (c[4:3])
            2'b01: begin
               lo = (i == 0) ? 0 : (longint'(PMPAdr[((i == 0) ? 0 : i-1)*AW +: AW]) << 2);
               hi = ad << 2;
            end
            2'b10: begin lo = ad << 2; hi = lo + 4; end
            2'b11: begin
               t = 0;
               while (t < AW && ad[t]) t++;
               rs = longint'(1) << (t + 3);
               lo = (ad << 2) & ~(rs - 1);
               hi = lo + rs;
            end
            default: ;
         endcase
         sin = (a0 >= lo) && (a0 < hi);
         lin = (a1 >= lo) && (a1 < hi);
         if (sin || lin) begin
            e.m = 1; e.idx = i; e.p = !(sin && lin);
            e.l = c[7]; e.x = c[2]; e.w = c[1]; e.r = c[0];
            break;
         end
      end
      e.lat = e.m ? (e.idx / LN + 2) : (NE / LN + 1);
      if (CACHE && cv && cpa == pa[PA-1:2] && csz == sz) e.lat = 1;
      return e;
   endfunction

   task automatic req(logic [PA-1:0] pa, logic [1:0] sz, int hold, output exp_t got);
      exp_t e, x;
      int n;
      e = model(pa, sz);
      sbq.push_back(e);
      @(negedge clk);
      chk("req_ready", ReqReady, 1);
      PhysicalAddress = pa; Size = sz; ReqValid = 1'b1;
      @(negedge clk);
      ReqValid = 1'b0;
      n = 1;
      while (!RespValid && n < 40) begin @(negedge clk); n++; end
      x = sbq.pop_front();
      chk("latency", n, x.lat);
      chk("match", Match, x.m);
      chk("idx", MatchIdx, x.idx);
      chk("partial", Partial, x.p);
      chk("lxwr", {L, X, W, R}, {x.l, x.x, x.w, x.r});
      got = '{m: Match, idx: int'(MatchIdx), p: Partial, l: L, x: X, w: W, r: R, lat: n};
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk("hold", {RespValid, Match, MatchIdx, Partial, L, X, W, R},
             {1'b1, x.m, 4'(x.idx), x.p, x.l, x.x, x.w, x.r});
      end
      RespReady = 1'b1;
      @(negedge clk);
      RespReady = 1'b0;
      chk("resp_drop", RespValid, 0);
      cv = 1'b1; cpa = pa[PA-1:2]; csz = sz;
   endtask

   task automatic flush();
      @(negedge clk); Flush = 1'b1;
      @(negedge clk); Flush = 1'b0;
      cv = 1'b0;
   endtask

   // Abort a long (all-miss) scan in its second scan cycle by Flush (kind 0) or reset (kind 1).
   task automatic abort(int kind);
      bit seen;
      @(negedge clk); PhysicalAddress = 34'h1000; Size = 2'd2; ReqValid = 1'b1;
      @(negedge clk); ReqValid = 1'b0;
      chk("abort_busy", ReqReady, 0);
      @(negedge clk);
      if (kind == 0) Flush = 1'b1; else reset = 1'b1;
      @(negedge clk); Flush = 1'b0; reset = 1'b0; cv = 1'b0;
      chk("abort_idle", {ReqReady, RespValid}, 2'b10);
      seen = 1'b0;
      repeat (6) begin @(negedge clk); if (RespValid) seen = 1'b1; end
      chk("abort_noresp", seen, 0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      exp_t g;
      logic [1:0] sz;
      logic [PA-1:0] pa;

      repeat (3) @(negedge clk);
      chk("rst_ready", ReqReady, 1);
      chk("rst_valid", RespValid, 0);
      chk("rst_outs", {Match, MatchIdx, Partial, L, X, W, R}, 0);
      reset = 1'b0;

      // NAPOT 4 KB at 0x10000 in entry 5, with backpressure on the first response.
      set_ent(5, 8'h1B, 32'h41FF); flush();
      req(34'h10010, 2'd2, 3, g);
      chk("napot_idx", g.idx, 5);
      chk("napot_lat", g.lat, 3);
      chk("napot_pxwr", {g.m, g.p, g.x, g.w, g.r}, 5'b10011);
      req(34'h10010, 2'd2, 0, g);
      chk("repeat_idx", g.idx, 5);
      flush();
      req(34'h10010, 2'd2, 0, g);
      chk("post_flush_lat", g.lat, 3);

      // TOR [0x4000,0x4004) in entry 1; entry 2 is an inverted TOR that never matches.
      PMPCfg = '0; PMPAdr = '0;
      set_ent(0, 8'h00, 32'h1000); set_ent(1, 8'h09, 32'h1001); set_ent(2, 8'h0B, 32'h1000);
      flush();
      req(34'h4000, 2'd3, 0, g);
      chk("tor_part", {g.m, 4'(g.idx), g.p}, {1'b1, 4'd1, 1'b1});
      req(34'h4000, 2'd2, 0, g);
      chk("tor_full", {g.m, g.p}, 2'b10);
      req(34'h4004, 2'd2, 0, g);
      chk("tor_edge_miss", g.m, 0);

      // Priority between overlapping NAPOTs, plus an NA4 partial in the last group.
      PMPCfg = '0; PMPAdr = '0;
      set_ent(2, 8'h1C, 32'h2000); set_ent(3, 8'h9B, 32'h21FF); set_ent(12, 8'h91, 32'h3000);
      flush();
      req(34'h8000, 2'd0, 0, g);
      chk("prio_idx", g.idx, 2);
      chk("prio_lat", g.lat, 2);
      req(34'h8008, 2'd3, 0, g);
      chk("prio_next", {4'(g.idx), g.l}, {4'd3, 1'b1});
      req(34'hC000, 2'd3, 0, g);
      chk("na4_last", {4'(g.idx), g.p, g.l, g.r}, {4'd12, 3'b111});

      // Everything OFF.
      PMPCfg = '0; PMPAdr = '0; flush();
      req(34'h1234, 2'd1, 0, g);
      chk("nomatch_lat", g.lat, 5);
      chk("nomatch_outs", {g.m, g.l, g.x, g.w, g.r}, 0);

      abort(0);
      abort(1);

      // Flush wins over a simultaneous request.
      @(negedge clk); PhysicalAddress = 34'h40; Size = 2'd0; ReqValid = 1'b1; Flush = 1'b1;
      @(negedge clk); ReqValid = 1'b0; Flush = 1'b0; cv = 1'b0;
      chk("flush_prio", {ReqReady, RespValid}, 2'b10);

      // Random configurations with repeated requests.
      for (int rnd = 0; rnd < 4; rnd++) begin
         for (int i = 0; i < NE; i++)
            set_ent(i, 8'($urandom) & 8'h9F, AW'($urandom_range(0, 'h5FFF)));
         flush();
         for (int q = 0; q < 5; q++) begin
            sz = 2'($urandom_range(0, 3));
            pa = PA'($urandom_range(0, 'h17FFF)) & ~(PA'(1 << sz) - PA'(1));
            req(pa, sz, 0, g);
            if (q == 4) req(pa, sz, 0, g);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
